req_walker: RTL and testbench

- Wishbone-classic (pipelined) slave that starts an LED "walker" when written.
- A write starts a single lit LED moving left across the LED bank and back again. The block then returns to idle.
- Reads return the current walker position.
- Used as a simple memory-mapped peripheral on the bus fabric, mainly as a bus/formal-verification demo target.

---
 rtl/req_walker_pkg.sv | 14 +
 rtl/req_walker_if.sv | 25 ++
 rtl/req_walker.sv | 84 ++++++++
 tb/tb_req_walker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/req_walker_pkg.sv
// Shared constants for the LED walker peripheral: bus width, default LED count
// and the derivation of the walker state-register width.
package req_walker_pkg;

    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 1;
    localparam int NLEDS_DEFAULT = 6;

    // Smallest width whose range covers idle plus all 2*nleds-1 walk steps.
    function automatic int state_width(input int nleds);
        return $clog2(2 * nleds);
    endfunction

endpackage

// File: rtl/req_walker_if.sv
// Pipelined Wishbone-classic slave port of the walker.
// Signal names are given from the slave's point of view.
interface req_walker_if;
    import req_walker_pkg::*;

    logic              i_cyc;
    logic              i_stb;
    logic              i_we;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic              o_stall;
    logic              o_ack;
    logic [DATA_W-1:0] o_data;

    modport slave (
        input  i_cyc, i_stb, i_we, i_addr, i_data,
        output o_stall, o_ack, o_data
    );

    modport master (
        output i_cyc, i_stb, i_we, i_addr, i_data,
        input  o_stall, o_ack, o_data
    );

endinterface

// File: rtl/req_walker.sv
// Wishbone slave that, on any write, walks a single lit LED left across the
// bank and back, then idles. Reads return the current walk position.
module req_walker
    import req_walker_pkg::*;
#(
    parameter int NLEDS = NLEDS_DEFAULT,
    parameter int SW    = state_width(NLEDS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    req_walker_if.slave      bus,
    output logic [NLEDS-1:0] o_led
);

    localparam logic [SW-1:0] LAST_STEP = SW'(2 * NLEDS - 1);

    logic [SW-1:0] state_q, state_d;
    logic          ack_q, ack_d;
    logic          req;
    logic          busy;
    logic          accept_write;

    // Step k lights bit k-1 on the way out and bit 2*NLEDS-1-k on the way back;
    // the two coincide at the turnaround, so each step matches exactly one bit.
    function automatic logic [NLEDS-1:0] led_decode(input logic [SW-1:0] st);
        logic [NLEDS-1:0] led;
        for (int i = 0; i < NLEDS; i++) begin
            led[i] = (st == SW'(i + 1)) || (st == SW'(2 * NLEDS - 1 - i));
        end
        return led;
    endfunction

    assign req          = bus.i_cyc && bus.i_stb;
    assign busy         = (state_q != '0);
    assign bus.o_stall  = busy && bus.i_we;
    assign accept_write = req && bus.i_we && !bus.o_stall;

    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        if (accept_write) begin
            state_d = SW'(1);
        end else if (state_q >= LAST_STEP) begin
            state_d = '0;
        end else if (busy) begin
            state_d = state_q + SW'(1);
        end
        if (bus.i_cyc) begin
            ack_d = bus.i_stb && !bus.o_stall;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.o_ack  = ack_q;
    assign bus.o_data = DATA_W'(state_q);
    assign o_led      = led_decode(state_q);

    // Address and write data carry no information: one register, any write starts.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.i_addr, bus.i_data};

    a_ack_has_request: assert property (@(posedge i_clk) disable iff (i_reset)
        bus.o_ack |-> $past(req && !bus.o_stall));

    a_stall_only_write_busy: assert property (@(posedge i_clk)
        bus.o_stall |-> (bus.i_we && busy));

    a_led_onehot: assert property (@(posedge i_clk)
        $onehot0(o_led) && (busy == (o_led != '0)));

endmodule

// File: tb/tb_req_walker.sv
// Directed bench for req_walker at default parameters (6 LEDs, 4-bit state).
module tb_req_walker;

    logic i_clk = 1'b0;
    logic i_reset;
    logic [5:0] o_led;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] led_tab [0:11] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10,
                                   6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01};

    req_walker_if bus ();

    req_walker dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus),
        .o_led   (o_led)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we);
        bus.i_cyc = cyc;
        bus.i_stb = stb;
        bus.i_we  = we;
    endtask

    // One-cycle write from idle; returns with the walk at step 1.
    task automatic start_walk();
        drive(1'b1, 1'b1, 1'b1);
        bus.i_data = 32'hDEAD_BEEF;
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_data != 32'h0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, bus.o_data, 32'h0);
    endtask

    initial begin
        i_reset    = 1'b1;
        bus.i_addr = 1'b0;
        bus.i_data = 32'h0;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        i_reset = 1'b0;

        check("rst_state", bus.o_data, 32'h0);
        check("rst_led",   32'(o_led), 32'h0);
        check("rst_ack",   32'(bus.o_ack), 32'h0);
        check("rst_stall", 32'(bus.o_stall), 32'h0);

        // Strobe without a bus cycle must neither ack nor start a walk.
        drive(1'b0, 1'b1, 1'b1);
        tick();
        check("nocyc_ack",   32'(bus.o_ack), 32'h0);
        check("nocyc_state", bus.o_data, 32'h0);
        drive(1'b0, 1'b0, 1'b0);

        // Full walk after a single write.
        drive(1'b1, 1'b1, 1'b1);
        #1;
        check("idle_write_stall", 32'(bus.o_stall), 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("walk_ack",   32'(bus.o_ack), 32'h1);
        check("walk_state", bus.o_data, 32'h1);
        check("walk_led1",  32'(o_led), 32'(led_tab[1]));
        for (int k = 2; k <= 12; k++) begin
            tick();
            check($sformatf("walk_led%0d", k), 32'(o_led), 32'(led_tab[k % 12]));
            check($sformatf("walk_state%0d", k), bus.o_data, 32'(k % 12));
            check($sformatf("walk_noack%0d", k), 32'(bus.o_ack), 32'h0);
        end

        // Write held from step 3 stalls until idle, then restarts the walk.
        start_walk();
        tick();
        tick();
        check("wr_busy_state", bus.o_data, 32'h3);
        drive(1'b1, 1'b1, 1'b1);
        #1;
        check("wr_busy_stall", 32'(bus.o_stall), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("wr_busy_noack%0d", i), 32'(bus.o_ack), 32'h0);
            check($sformatf("wr_busy_step%0d", i), bus.o_data, 32'(3 + i));
        end
        tick();
        check("wr_idle_state", bus.o_data, 32'h0);
        check("wr_idle_stall", 32'(bus.o_stall), 32'h0);
        check("wr_idle_noack", 32'(bus.o_ack), 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("wr_restart_ack",   32'(bus.o_ack), 32'h1);
        check("wr_restart_state", bus.o_data, 32'h1);
        wait_idle("wr_restart_done");

        // Read at step 5 is never stalled; ack carries the advanced position.
        start_walk();
        repeat (4) tick();
        drive(1'b1, 1'b1, 1'b0);
        #1;
        check("rd_busy_stall", 32'(bus.o_stall), 32'h0);
        tick();
        check("rd_busy_ack",  32'(bus.o_ack), 32'h1);
        check("rd_busy_data", bus.o_data, 32'h6);
        // Dropping cyc mid-walk kills the ack but not the walk.
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check("nocyc_walk_ack",   32'(bus.o_ack), 32'h0);
        check("nocyc_walk_state", bus.o_data, 32'h7);
        drive(1'b0, 1'b0, 1'b0);
        wait_idle("rd_walk_done");

        // Back-to-back reads in idle give back-to-back acks.
        drive(1'b1, 1'b1, 1'b0);
        tick();
        check("b2b_ack1", 32'(bus.o_ack), 32'h1);
        tick();
        check("b2b_ack2", 32'(bus.o_ack), 32'h1);
        check("b2b_data", bus.o_data, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("b2b_end", 32'(bus.o_ack), 32'h0);

        // Reset at step 7 with a read in flight drops state and the pending ack.
        start_walk();
        repeat (6) tick();
        check("mid_rst_pre", bus.o_data, 32'h7);
        drive(1'b1, 1'b1, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        check("mid_rst_state", bus.o_data, 32'h0);
        check("mid_rst_led",   32'(o_led), 32'h0);
        check("mid_rst_ack",   32'(bus.o_ack), 32'h0);
        start_walk();
        check("post_rst_ack",   32'(bus.o_ack), 32'h1);
        check("post_rst_state", bus.o_data, 32'h1);
        check("post_rst_led",   32'(o_led), 32'h01);
        wait_idle("post_rst_done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
